// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline-stage bridge: occupancy type,
// default bubble value and the standard partition widths of the RISC-V stages.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam logic [63:0] PIPE_CTRL_BUBBLE = 64'h0;

  localparam int IFID_CTRL_W  = 8;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 160;
  localparam int EXMEM_CTRL_W = 8;
  localparam int EXMEM_DATA_W = 96;
  localparam int MEMWB_CTRL_W = 4;
  localparam int MEMWB_DATA_W = 64;

  function automatic occ_t occ_count(input logic m_valid, input logic s_valid);
    return {1'b0, m_valid} + {1'b0, s_valid};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake, payload, flush and occupancy bundle of one pipeline-stage bridge.
// slave = the stage itself, master = the surrounding pipeline / bench.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  occ_t              occupancy;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready, flush,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready, flush,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_slot.sv
// One beat register: valid bit, control and data partitions. kill clears valid
// and loads the bubble into ctrl while data is retained.
module pipe_slot #(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 160,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              kill,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // slot state; kill outranks load so a flushed beat never survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= CTRL_BUBBLE;
      data  <= {DATA_W{1'b0}};
    end else if (kill) begin
      valid <= 1'b0;
      ctrl  <= CTRL_BUBBLE;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage bridge with a flushable control partition.
// Define PIPE_STAGE_SKID_EN to add the skid slot and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 160,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(PIPE_CTRL_BUBBLE)
) (
  input logic             clk,
  input logic             rst_n,
  pipe_stage_reg_if.slave bus
);

  logic              m_valid_s;
  logic [CTRL_W-1:0] m_ctrl_s;
  logic [DATA_W-1:0] m_data_s;
  logic              m_load_s;
  logic              m_kill_s;
  logic              m_from_s_s;
  logic [CTRL_W-1:0] m_ld_ctrl_s;
  logic [DATA_W-1:0] m_ld_data_s;
  logic              s_valid_s;
  logic [CTRL_W-1:0] s_ctrl_s;
  logic [DATA_W-1:0] s_data_s;
  logic              accept_s;
  logic              deliver_s;

`ifdef PIPE_STAGE_SKID_EN
  logic s_load_s;
  logic s_kill_s;
`endif

  assign accept_s  = bus.in_valid & bus.in_ready;
  assign deliver_s = m_valid_s & bus.out_ready;

  // slot move decision; flush outranks both delivery and acceptance
  always_comb begin
    m_load_s   = 1'b0;
    m_kill_s   = 1'b0;
    m_from_s_s = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    s_load_s   = 1'b0;
    s_kill_s   = 1'b0;
`endif
    if (bus.flush) begin
      m_kill_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
      s_kill_s = 1'b1;
`endif
    end else if (deliver_s) begin
      if (s_valid_s) begin
        m_load_s   = 1'b1;
        m_from_s_s = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
        s_kill_s   = 1'b1;
`endif
      end else if (accept_s) begin
        m_load_s = 1'b1;
      end else begin
        m_kill_s = 1'b1;
      end
    end else if (!m_valid_s) begin
      m_load_s = accept_s;
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      s_load_s = accept_s;
`endif
    end
  end

  assign m_ld_ctrl_s = m_from_s_s ? s_ctrl_s : bus.in_ctrl;
  assign m_ld_data_s = m_from_s_s ? s_data_s : bus.in_data;

  pipe_slot #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_m (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (m_load_s),
    .kill    (m_kill_s),
    .ld_ctrl (m_ld_ctrl_s),
    .ld_data (m_ld_data_s),
    .valid   (m_valid_s),
    .ctrl    (m_ctrl_s),
    .data    (m_data_s)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_slot #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_s (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (s_load_s),
    .kill    (s_kill_s),
    .ld_ctrl (bus.in_ctrl),
    .ld_data (bus.in_data),
    .valid   (s_valid_s),
    .ctrl    (s_ctrl_s),
    .data    (s_data_s)
  );

  // registered ready: no path from out_ready
  assign bus.in_ready = ~s_valid_s;
`else
  assign s_valid_s    = 1'b0;
  assign s_ctrl_s     = CTRL_BUBBLE;
  assign s_data_s     = {DATA_W{1'b0}};
  assign bus.in_ready = ~m_valid_s | bus.out_ready;
`endif

  assign bus.out_valid = m_valid_s;
  assign bus.out_ctrl  = m_ctrl_s;
  assign bus.out_data  = m_data_s;
  assign bus.occupancy = occ_count(m_valid_s, s_valid_s);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// valid/ready/flush traffic against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 160;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  beat_t         q[$];
  logic [DW-1:0] last_d = '0;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  // stage capacity is two beats with skid, one beat (plus pass-through) without
  function automatic logic model_in_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || (bus.out_ready == 1'b1);
  endfunction

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_ctrl   = c;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // one clock edge; the queue model follows the accept/deliver/flush rules
  task automatic step();
    logic  acc, del, fl;
    beat_t b;
    acc = bus.in_valid && model_in_ready();
    del = (q.size() != 0) && bus.out_ready;
    fl  = bus.flush;
    b.c = bus.in_ctrl;
    b.d = bus.in_data;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    if (q.size() != 0) last_d = q[0].d;
  endtask

  task automatic test_reset();
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0);
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.out_ctrl !== 16'h0) begin errors++; $display("FAIL rst_out_ctrl got=%h exp=0000", bus.out_ctrl); end
    checks++; if (bus.out_data !== {DW{1'b0}}) begin errors++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
    q.delete();
    last_d = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [DW-1:0] ed;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i * 3), DW'(i), 1'b1, 1'b0);
      step();
      ed = DW'(i);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat=%0d got=%0b exp=1", i, bus.out_valid); end
      checks++; if (bus.out_data !== ed) begin errors++; $display("FAIL stream_data beat=%0d got=%h exp=%h", i, bus.out_data, ed); end
      checks++; if (bus.out_ctrl !== 16'(i * 3)) begin errors++; $display("FAIL stream_ctrl beat=%0d got=%h exp=%h", i, bus.out_ctrl, 16'(i * 3)); end
      checks++; if (bus.occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ beat=%0d got=%0d exp=1", i, bus.occupancy); end
    end
    drive(1'b0, 16'h0, '0, 1'b1, 1'b0);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h000A, DW'(32'hA), 1'b0, 1'b0);
    step();
    checks++; if (bus.in_ready !== SKID) begin errors++; $display("FAIL bp_ready1 got=%0b exp=%0b", bus.in_ready, SKID); end
    drive(1'b1, 16'h000B, DW'(32'hB), 1'b0, 1'b0);
    step();
    checks++; if (bus.occupancy !== (SKID ? 2'd2 : 2'd1)) begin errors++; $display("FAIL bp_occ got=%0d exp=%0d", bus.occupancy, SKID ? 2 : 1); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got=%0b exp=0", bus.in_ready); end
    step();
    checks++; if (bus.out_data !== DW'(32'hA)) begin errors++; $display("FAIL bp_stable got=%h exp=a", bus.out_data); end
    drive(1'b1, 16'h000B, DW'(32'hB), 1'b1, 1'b0);
    step();
    checks++; if (bus.out_data !== DW'(32'hB) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second got=%h/%0b exp=b/1", bus.out_data, bus.out_valid); end
    drive(1'b0, 16'h0, '0, 1'b1, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready3 got=%0b exp=1", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 2'd0) begin errors++; $display("FAIL bp_drain got=%0b/%0d exp=0/0", bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_flush();
    drive(1'b1, 16'h00FF, DW'(32'h1234), 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0F0F, DW'(32'h5678), 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hAAAA, DW'(32'h9999), 1'b0, 1'b1);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_ctrl !== 16'h0000) begin errors++; $display("FAIL flush_ctrl got=%h exp=0000", bus.out_ctrl); end
    checks++; if (bus.out_data !== DW'(32'h1234)) begin errors++; $display("FAIL flush_data got=%h exp=1234", bus.out_data); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", bus.occupancy); end
    drive(1'b1, 16'h0055, DW'(32'h4321), 1'b1, 1'b0);
    step();
    // ready is high here, so the flush must discard an otherwise accepted beat
    drive(1'b1, 16'h0066, DW'(32'h8765), 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, '0, 1'b1, 1'b0);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== DW'(32'h4321)) begin errors++; $display("FAIL flush_keep_data got=%h exp=4321", bus.out_data); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 16'h0011, DW'(32'h11), 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0022, DW'(32'h22), 1'b0, 1'b0);
    step();
    checks++; if (bus.occupancy !== (SKID ? 2'd2 : 2'd1)) begin errors++; $display("FAIL ar_occ_before got=%0d", bus.occupancy); end
    drive(1'b0, 16'h0, '0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.occupancy !== 2'd0) begin errors++; $display("FAIL ar_occ got=%0d exp=0", bus.occupancy); end
    checks++; if (bus.out_ctrl !== 16'h0 || bus.out_data !== {DW{1'b0}}) begin errors++; $display("FAIL ar_payload got=%h/%h exp=0/0", bus.out_ctrl, bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got=%0b exp=1", bus.in_ready); end
    q.delete();
    last_d = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic          held = 1'b0;
    logic          v;
    logic [CW-1:0] c = '0;
    logic [DW-1:0] d = '0;
    logic          ordy;
    logic          rdy0;
    logic          ev;
    for (int i = 0; i < 10000; i++) begin
      v = held ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!held) begin
        c = 16'($urandom);
        d = {32'(i), 96'h0, 32'($urandom)};
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive(v, c, d, ordy, $urandom_range(0, 31) == 0);
      #1;
      ev = (q.size() != 0);
      checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, bus.out_valid, ev); end
      checks++; if (bus.out_ctrl !== (ev ? q[0].c : 16'h0)) begin errors++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", i, bus.out_ctrl, ev ? q[0].c : 16'h0); end
      checks++; if (bus.out_data !== (ev ? q[0].d : last_d)) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, bus.out_data, ev ? q[0].d : last_d); end
      checks++; if (bus.occupancy !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", i, bus.occupancy, q.size()); end
      checks++; if (bus.in_ready !== model_in_ready()) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, bus.in_ready, model_in_ready()); end
      if (SKID) begin
        rdy0 = bus.in_ready;
        bus.out_ready = ~ordy;
        #1;
        checks++; if (bus.in_ready !== rdy0) begin errors++; $display("FAIL rnd_ready_path cyc=%0d got=%0b exp=%0b", i, bus.in_ready, rdy0); end
        bus.out_ready = ordy;
        #1;
      end
      held = bus.in_valid && !model_in_ready();
      step();
    end
    drive(1'b0, 16'h0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step();
    checks++; if (bus.out_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rnd_drain got=%0b left=%0d exp=0/0", bus.out_valid, q.size()); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage bridge for the interrupt-capable RISC-V pipeline. It replaces the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB bridges with one block. The payload is split into a control partition, cleared to a bubble value on flush, and a data partition, retained on flush. A valid/ready handshake replaces the global enable, and an optional skid slot provides full throughput with a registered `in_ready`.

## Interface
Parameters:
- `CTRL_W`, 16: width of the control partition (RegWrite, MemWrite, branch/jump flags, ALU_OP and similar); cleared on flush.
- `DATA_W`, 160: width of the data partition (PC, IR, R1, R2, imm); kept on flush.
- `CTRL_BUBBLE`, `'0`: value driven on the control partition when the stage holds no valid beat.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: upstream beat present.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_ctrl` in `CTRL_W`: upstream control partition.
- `in_data` in `DATA_W`: upstream data partition.
- `out_valid` out 1: beat presented downstream.
- `out_ready` in 1: downstream consumes the beat this cycle.
- `out_ctrl` out `CTRL_W`: control partition of the head beat, or `CTRL_BUBBLE` when `out_valid`=0.
- `out_data` out `DATA_W`: data partition of the head beat, or the last held data when `out_valid`=0.
- `flush` in 1: kill all held beats (branch redirect, `Int_Enter`, `uret`).
- `occupancy` out 2: number of held beats, 0..2.

## Operation
- Storage:
  - Main slot M drives the outputs.
  - Skid slot S exists only with `PIPE_STAGE_SKID_EN`.
  - Each slot holds a valid bit, ctrl and data.
- Accept: `in_valid & in_ready` at a rising edge. Deliver: `out_valid & out_ready`.
- Slot moves, non-flush cycle:
  - **Deliver, S empty:** M loads the incoming beat if one is accepted, otherwise M becomes invalid.
  - **Deliver, S full:** M takes S and S empties.
  - **No deliver, M empty:** M loads the accepted beat.
  - **No deliver, M full:** S loads the accepted beat (skid only).
- Order: beats leave in acceptance order. No duplication and no loss except by flush.
- Flush:
  - All valid bits clear next edge and ctrl of every slot loads `CTRL_BUBBLE`.
  - Data partitions keep their values, so PC and IR stay observable for `mepc` capture.
  - Flush has priority over accept: a beat accepted in the flush cycle is discarded.
  - Flush has priority over deliver: a delivery in the flush cycle still counts as consumed downstream.
- `in_ready` with skid is `!S.valid`, a pure register output with no combinational path from `out_ready`.
- `occupancy` is `M.valid + S.valid`.
- Required invariant: `S.valid` implies `M.valid`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `out_valid`=0, `occupancy`=0, `out_ctrl`=`CTRL_BUBBLE`, `out_data`=0.
  - `in_ready`=1 with skid; `in_ready`=1 (M empty) without skid.
- Reset deassertion is synchronised outside the block. The first accept is allowed on the first edge with `rst_n`=1.
- Latency: a beat accepted at edge N appears on `out_*` after edge N, i.e. in cycle N+1. One cycle, both configurations.
- Throughput: one beat per cycle sustained while `out_ready`=1.
- Stall:
  - When `out_ready`=0, `out_*` hold stable until delivery.
  - Upstream must hold `in_*` stable while `in_valid & !in_ready`.
- Flush takes effect at the next edge. `out_valid`=0 in the following cycle, with `out_ctrl`=`CTRL_BUBBLE`.
- Simultaneous flush with `rst_n` low: reset wins.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`.
- **Defined:**
  - The S slot is instantiated.
  - `in_ready` = `!S.valid` (registered).
  - `occupancy` ranges 0..2.
- **Undefined:**
  - Single slot M.
  - `in_ready` = `!M.valid | out_ready` (combinational, matching the legacy en-stall behaviour).
  - `occupancy` ranges 0..1, bit 1 tied to 0.
- Latency and flush semantics are identical in both configurations.

## Structure
- Shared package `pipe_pkg`:
  - `occ_t` (2-bit occupancy type).
  - Default bubble constant `PIPE_CTRL_BUBBLE`.
  - Standard partition widths: `IFID_CTRL_W`, `IDEX_CTRL_W`, `IDEX_DATA_W`, etc.
- Sub-module `pipe_slot`: one valid/ctrl/data register with load, clear-ctrl and async reset, instantiated as M and, under the macro, as S.
- Existing fixed bridges become thin instances that concatenate their fields into `in_ctrl`/`in_data`.

## Test plan
- **Streaming:** reset, then 8 beats with data 0x1..0x8 and `out_ready`=1 → `out_valid` from cycle 2, data 0x1..0x8 in consecutive cycles, `occupancy`=1.
- **Backpressure (skid):** `out_ready`=0 while beats 0xA, 0xB are offered → both accepted; `in_ready`=0 after the second, `occupancy`=2, `out_data`=0xA stable. Then `out_ready`=1 → 0xA, 0xB delivered in order, `in_ready` returns to 1.
- **Backpressure (no skid):** same stimulus → 0xB is held upstream (`in_ready`=0) until 0xA is delivered.
- **Flush with M and S full:**
  - Stimulus: ctrl 0x00FF, data 0x1234 in M; assert `flush` with `in_valid`=1.
  - Response: next cycle `out_valid`=0, `out_ctrl`=0x0000, `out_data`=0x1234, `occupancy`=0. The concurrent input beat never appears.
- **Async reset mid-stall:** drop `rst_n` between clock edges with `occupancy`=2 → outputs go to reset values immediately, before the next edge.
- **Random valid/ready:** 10k cycles with a scoreboard → in-order delivery with no loss or duplication. With skid, no cycle shows `in_ready` depending on same-cycle `out_ready`.
